// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder: physical pointer,
// cacheline, line-index type, FSM state encoding and an address helper.
package dmem_responder_pkg;

  localparam int PPTR_W          = 32;
  localparam int DCACHE_OFFSET_W = 4;
  localparam int CACHELINE_W     = 128;
  localparam int DMEM_LATENCY    = 5;
  localparam int DMEM_LINES      = 4096;

  typedef logic [PPTR_W-1:0]             pptr_t;
  typedef logic [CACHELINE_W-1:0]        cacheline_t;
  typedef logic [$clog2(DMEM_LINES)-1:0] dmem_line_idx_t;

  typedef enum logic [1:0] {
    DMEM_IDLE    = 2'd0,
    DMEM_COUNT   = 2'd1,
    DMEM_RESPOND = 2'd2
  } dmem_state_e;

  // Clear the byte-offset field so the address names a whole cacheline.
  function automatic pptr_t dmem_line_align(pptr_t addr);
    return {addr[PPTR_W-1:DCACHE_OFFSET_W], {DCACHE_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dmem_req_fifo.sv
// Synchronous FIFO holding outstanding line-fill reads. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
module dmem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] slots_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = slots_q[rd_ptr_q[PTR_W-1:0]];

  // Advance each pointer by one when its side of the FIFO moves.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Slot storage needs no reset: a slot is only read after it is written.
  always_ff @(posedge clk_i) begin
    if (do_push) slots_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Behavioural main memory for the data cache. Write-backs land in storage on
// the request edge; line-fill reads are queued and answered in order after
// MEM_LATENCY cycles. Build macro DMEM_RESPONDER_PIPELINED_EN gives every
// queued read its own age so responses may follow one per cycle; without it
// a single latency counter serializes the reads.
//
// Handshake: there is no ready. A request is a one-cycle pulse on req_ren or
// req_wen. Writes are always taken. A read is taken only when req_full was
// low before the edge; otherwise it is dropped and overflow latches. Each
// taken read yields exactly one single-cycle rec_en pulse, in request order.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = DMEM_LATENCY,
  parameter int QUEUE_DEPTH = 4,
  parameter int MEM_LINES   = DMEM_LINES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_ren,
  input  logic [PPTR_W-1:0]      req_raddr,
  input  logic                   req_wen,
  input  logic [PPTR_W-1:0]      req_waddr,
  input  logic [CACHELINE_W-1:0] req_wcacheline,
  output logic                   rec_en,
  output logic [PPTR_W-1:0]      rec_addr,
  output logic [CACHELINE_W-1:0] rec_cacheline,
  output logic                   req_full,
  output logic                   overflow,
  output logic [1:0]             dbg_state_o
);

  localparam int LINE_W = $clog2(MEM_LINES);
`ifdef DMEM_RESPONDER_PIPELINED_EN
  // Wide enough that the oldest possible head age never wraps.
  localparam int AGE_W   = $clog2(MEM_LATENCY + QUEUE_DEPTH + 1) + 1;
  localparam int ENTRY_W = PPTR_W + AGE_W;
`else
  localparam int CNT_W   = $clog2(MEM_LATENCY + 1);
  localparam int ENTRY_W = PPTR_W;
`endif

  logic [CACHELINE_W-1:0] mem_q [MEM_LINES];
  logic [LINE_W-1:0]      w_idx, h_idx;
  logic [PPTR_W-1:0]      head_addr;
  logic [CACHELINE_W-1:0] rd_line;
  logic [ENTRY_W-1:0]     push_entry, head_entry;
  logic                   fifo_push, fifo_full, fifo_empty, fire;
  dmem_state_e            state_q, state_d;

  logic                   rec_en_q;
  logic [PPTR_W-1:0]      rec_addr_q;
  logic [CACHELINE_W-1:0] rec_line_q;
  logic                   overflow_q;
  logic                   unused_addr_bits;

  assign w_idx     = req_waddr[DCACHE_OFFSET_W +: LINE_W];
  assign h_idx     = head_addr[DCACHE_OFFSET_W +: LINE_W];
  assign fifo_push = req_ren && !fifo_full;
  // A write on the response edge commits first, so forward it to the read.
  assign rd_line   = (req_wen && (w_idx == h_idx)) ? req_wcacheline : mem_q[h_idx];
  assign unused_addr_bits = ^{req_waddr[DCACHE_OFFSET_W-1:0],
                              req_waddr[PPTR_W-1:DCACHE_OFFSET_W+LINE_W],
                              req_raddr[DCACHE_OFFSET_W-1:0]};

  dmem_req_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_req_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .pop_i   (fire),
    .data_i  (push_entry),
    .head_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Backing storage is not reset so data survives a responder reset.
  always_ff @(posedge clk) begin
    if (req_wen) mem_q[w_idx] <= req_wcacheline;
  end

`ifdef DMEM_RESPONDER_PIPELINED_EN
  logic [AGE_W-1:0] stamp_q, head_stamp, head_age;
  logic             head_ready;

  // Stamp is the value the free-running counter takes after the accept edge,
  // making the age zero in the cycle right after acceptance.
  assign push_entry = {dmem_line_align(req_raddr), stamp_q + AGE_W'(1)};
  assign head_addr  = head_entry[ENTRY_W-1 -: PPTR_W];
  assign head_stamp = head_entry[AGE_W-1:0];
  assign head_age   = stamp_q - head_stamp;
  assign head_ready = !fifo_empty && (head_age >= AGE_W'(MEM_LATENCY - 1));

  // State register and free-running age counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DMEM_IDLE;
      stamp_q <= '0;
    end else begin
      state_q <= state_d;
      stamp_q <= stamp_q + AGE_W'(1);
    end
  end

  // Respond whenever the oldest read has aged enough; at most one per cycle.
  always_comb begin
    state_d = head_ready ? DMEM_RESPOND : DMEM_IDLE;
  end
`else
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign push_entry = dmem_line_align(req_raddr);
  assign head_addr  = head_entry;

  // State register and latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Serialized sequencing: one read in flight, counted out before responding.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DMEM_IDLE, DMEM_RESPOND: begin
        if (!fifo_empty) begin
          if (MEM_LATENCY == 1) begin
            state_d = DMEM_RESPOND;
            cnt_d   = '0;
          end else begin
            state_d = DMEM_COUNT;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          state_d = DMEM_IDLE;
          cnt_d   = '0;
        end
      end
      DMEM_COUNT: begin
        if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
          state_d = DMEM_RESPOND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DMEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`endif

  // Entering RESPOND loads the response registers and pops the head.
  always_comb begin
    fire = (state_d == DMEM_RESPOND);
  end

  // Response registers and the sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_en_q   <= 1'b0;
      rec_addr_q <= '0;
      rec_line_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rec_en_q <= fire;
      if (fire) begin
        rec_addr_q <= head_addr;
        rec_line_q <= rd_line;
      end
      if (req_ren && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign rec_en        = rec_en_q;
  assign rec_addr      = rec_addr_q;
  assign rec_cacheline = rec_line_q;
  assign req_full      = fifo_full;
  assign overflow      = overflow_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. A time-based reference model
// predicts, per accepted read, the edge of its response and the line it
// carries; a scoreboard compares every cycle, and scenario tasks add
// targeted checks.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int L     = 5;
  localparam int QD    = 4;
  localparam int LINES = 4096;
  localparam int AW    = 32;
  localparam int CW    = 128;
  localparam int EW    = 32 + AW + CW;
`ifdef DMEM_RESPONDER_PIPELINED_EN
  localparam int GAP = 1;
`else
  localparam int GAP = L;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_ren = 1'b0;
  logic [AW-1:0] req_raddr = '0;
  logic          req_wen = 1'b0;
  logic [AW-1:0] req_waddr = '0;
  logic [CW-1:0] req_wcacheline = '0;
  logic          rec_en;
  logic [AW-1:0] rec_addr;
  logic [CW-1:0] rec_cacheline;
  logic          req_full;
  logic          overflow;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  logic [CW-1:0] mdl_mem [int];
  int            pend_t[$];
  logic [AW-1:0] pend_a[$];
  int            last_t = -1000;
  int            mdl_occ;
  int            mdl_acc_cnt = 0;
  int            mdl_t;
  logic          mdl_full = 1'b0;
  logic          mdl_ovf  = 1'b0;
  logic [EW-1:0] exp_q[$];

  logic          mon_exp_en;
  logic [EW-1:0] mon_e;

  always #5 clk = ~clk;

  dmem_responder #(
    .MEM_LATENCY (L),
    .QUEUE_DEPTH (QD),
    .MEM_LINES   (LINES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_ren        (req_ren),
    .req_raddr      (req_raddr),
    .req_wen        (req_wen),
    .req_waddr      (req_waddr),
    .req_wcacheline (req_wcacheline),
    .rec_en         (rec_en),
    .rec_addr       (rec_addr),
    .rec_cacheline  (rec_cacheline),
    .req_full       (req_full),
    .overflow       (overflow),
    .dbg_state_o    (dbg_state)
  );

  function automatic int line_of(logic [AW-1:0] a);
    return int'((a >> 4) % LINES);
  endfunction

  // ---------------- reference model ----------------
  always @(negedge rst) begin
    pend_t.delete(); pend_a.delete(); exp_q.delete();
    mdl_full = 1'b0; mdl_ovf = 1'b0; last_t = -1000;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      pend_t.delete(); pend_a.delete(); exp_q.delete();
      mdl_full = 1'b0; mdl_ovf = 1'b0; last_t = -1000;
    end else begin
      if (req_wen) mdl_mem[line_of(req_waddr)] = req_wcacheline;
      mdl_occ = pend_t.size();
      if (pend_t.size() > 0 && pend_t[0] == cyc) begin
        exp_q.push_back({32'(cyc), pend_a[0], mdl_mem[line_of(pend_a[0])]});
        void'(pend_t.pop_front());
        void'(pend_a.pop_front());
      end
      if (req_ren) begin
        if (mdl_occ >= QD) mdl_ovf = 1'b1;
        else begin
          mdl_t = (cyc + L > last_t + GAP) ? cyc + L : last_t + GAP;
          pend_t.push_back(mdl_t);
          pend_a.push_back(req_raddr & ~32'hF);
          last_t = mdl_t;
          mdl_acc_cnt++;
        end
      end
      mdl_full = (pend_t.size() == QD);
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    mon_exp_en = (exp_q.size() > 0) && (exp_q[0][EW-1 -: 32] == 32'(cyc));
    checks++;
    if (rec_en !== mon_exp_en) begin
      errors++;
      $display("FAIL sb_rec_en edge=%0d got=%b exp=%b", cyc, rec_en, mon_exp_en);
    end
    if (mon_exp_en) begin
      mon_e = exp_q.pop_front();
      if (rec_en === 1'b1) begin
        checks++;
        if (rec_addr !== mon_e[CW +: AW]) begin
          errors++;
          $display("FAIL sb_rec_addr edge=%0d got=%h exp=%h", cyc, rec_addr, mon_e[CW +: AW]);
        end
        checks++;
        if (rec_cacheline !== mon_e[CW-1:0]) begin
          errors++;
          $display("FAIL sb_rec_data edge=%0d got=%h exp=%h", cyc, rec_cacheline, mon_e[CW-1:0]);
        end
      end
    end
    checks++;
    if (req_full !== mdl_full) begin
      errors++;
      $display("FAIL sb_req_full edge=%0d got=%b exp=%b", cyc, req_full, mdl_full);
    end
    checks++;
    if (overflow !== mdl_ovf) begin
      errors++;
      $display("FAIL sb_overflow edge=%0d got=%b exp=%b", cyc, overflow, mdl_ovf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
    @(negedge clk);
    req_wen = 1'b1; req_waddr = a; req_wcacheline = d;
    @(negedge clk);
    req_wen = 1'b0;
  endtask

  function automatic logic [CW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rec_en !== 1'b0) begin errors++; $display("FAIL rst_rec_en got=%b exp=0", rec_en); end
    checks++; if (rec_addr !== '0) begin errors++; $display("FAIL rst_rec_addr got=%h exp=0", rec_addr); end
    checks++; if (rec_cacheline !== '0) begin errors++; $display("FAIL rst_rec_data got=%h exp=0", rec_cacheline); end
    checks++; if (req_full !== 1'b0) begin errors++; $display("FAIL rst_req_full got=%b exp=0", req_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    rst = 1'b1;
  endtask

  task automatic test_read_latency();
    int acc, rt; logic got; logic [AW-1:0] ra; logic [CW-1:0] rd;
    do_write(32'h0000_0400, {16{8'hA5}});
    req_ren = 1'b1; req_raddr = 32'h0000_0409;
    @(negedge clk); acc = cyc; req_ren = 1'b0;
    got = 1'b0; rt = 0; ra = '0; rd = '0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rec_en === 1'b1) begin got = 1'b1; rt = cyc; ra = rec_addr; rd = rec_cacheline; end
    end
    checks++; if (!got) begin errors++; $display("FAIL lat_timeout got=none exp=response"); end
    checks++; if (rt - acc != L) begin errors++; $display("FAIL lat_cycles got=%0d exp=%0d", rt - acc, L); end
    checks++; if (ra !== 32'h0000_0400) begin errors++; $display("FAIL lat_addr got=%h exp=00000400", ra); end
    checks++; if (rd !== {16{8'hA5}}) begin errors++; $display("FAIL lat_data got=%h exp=a5..a5", rd); end
  endtask

  task automatic test_same_cycle();
    logic got; logic [AW-1:0] ra; logic [CW-1:0] rd;
    @(negedge clk);
    req_wen = 1'b1; req_waddr = 32'h0000_0100; req_wcacheline = {16{8'h11}};
    req_ren = 1'b1; req_raddr = 32'h0000_0105;
    @(negedge clk); req_wen = 1'b0; req_ren = 1'b0;
    got = 1'b0; ra = '0; rd = '0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rec_en === 1'b1) begin got = 1'b1; ra = rec_addr; rd = rec_cacheline; end
    end
    checks++; if (!got) begin errors++; $display("FAIL same_timeout got=none exp=response"); end
    checks++; if (ra !== 32'h0000_0100) begin errors++; $display("FAIL same_addr got=%h exp=00000100", ra); end
    checks++; if (rd !== {16{8'h11}}) begin errors++; $display("FAIL same_data got=%h exp=11..11", rd); end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] d [4];
    logic [AW-1:0] a [4];
    int acc0, n;
    int rt [4]; logic [AW-1:0] ra [4]; logic [CW-1:0] rdat [4];
    for (int k = 0; k < 4; k++) begin
      a[k] = 32'h0000_2000 + 32'(k * 16);
      d[k] = rand_line();
      do_write(a[k], d[k]);
    end
    @(negedge clk);
    req_ren = 1'b1; req_raddr = a[0] | 32'($urandom_range(0, 15));
    @(negedge clk); acc0 = cyc;
    for (int k = 1; k < 4; k++) begin
      req_raddr = a[k] | 32'($urandom_range(0, 15));
      @(negedge clk);
    end
    req_ren = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (rec_en === 1'b1) begin rt[n] = cyc; ra[n] = rec_addr; rdat[n] = rec_cacheline; n++; end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (rt[k] != acc0 + L + k * GAP) begin errors++; $display("FAIL b2b_time[%0d] got=%0d exp=%0d", k, rt[k] - acc0, L + k * GAP); end
      checks++;
      if (ra[k] !== a[k]) begin errors++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", k, ra[k], a[k]); end
      checks++;
      if (rdat[k] !== d[k]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, rdat[k], d[k]); end
    end
  endtask

  task automatic test_overflow();
    int n;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (req_full !== (k - 1 >= 3)) begin errors++; $display("FAIL ovf_full[%0d] got=%b exp=%b", k - 1, req_full, (k - 1 >= 3)); end
      end
      req_ren = 1'b1; req_raddr = 32'h0000_2000 + 32'(k * 16);
    end
    @(negedge clk); req_ren = 1'b0;
    checks++; if (req_full !== 1'b1) begin errors++; $display("FAIL ovf_full_after5 got=%b exp=1", req_full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rec_en === 1'b1) n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL ovf_responses got=%0d exp=4", n); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_write_after_read();
    logic [CW-1:0] d0, d1; logic got; logic [CW-1:0] rd;
    d0 = rand_line(); d1 = ~d0;
    do_write(32'h0000_3000, d0);
    req_ren = 1'b1; req_raddr = 32'h0000_3003;
    @(negedge clk); req_ren = 1'b0;
    @(negedge clk);
    req_wen = 1'b1; req_waddr = 32'h0000_300C; req_wcacheline = d1;
    @(negedge clk); req_wen = 1'b0;
    got = 1'b0; rd = '0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rec_en === 1'b1) begin got = 1'b1; rd = rec_cacheline; end
    end
    checks++; if (!got) begin errors++; $display("FAIL war_timeout got=none exp=response"); end
    checks++; if (rd !== d1) begin errors++; $display("FAIL war_data got=%h exp=%h", rd, d1); end
  endtask

  task automatic test_random();
    int base_acc, nresp;
    for (int k = 0; k < 16; k++) do_write(32'(k * 16), rand_line());
    base_acc = mdl_acc_cnt;
    nresp = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rec_en === 1'b1) nresp++;
      req_ren   = ($urandom_range(0, 99) < 40);
      req_raddr = ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
      req_wen   = ($urandom_range(0, 99) < 30);
      req_waddr = ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
      req_wcacheline = rand_line();
    end
    @(negedge clk);
    if (rec_en === 1'b1) nresp++;
    req_ren = 1'b0; req_wen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rec_en === 1'b1) nresp++;
    end
    checks++;
    if (nresp != mdl_acc_cnt - base_acc) begin
      errors++; $display("FAIL rand_resp_count got=%0d exp=%0d", nresp, mdl_acc_cnt - base_acc);
    end
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] d; int n; logic got; logic [CW-1:0] rd;
    d = rand_line();
    do_write(32'h0000_0200, d);
    req_ren = 1'b1; req_raddr = 32'h0000_0208;
    @(negedge clk); req_ren = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (rec_en !== 1'b0) begin errors++; $display("FAIL mid_rec_en got=%b exp=0", rec_en); end
    checks++; if (rec_addr !== '0) begin errors++; $display("FAIL mid_rec_addr got=%h exp=0", rec_addr); end
    checks++; if (rec_cacheline !== '0) begin errors++; $display("FAIL mid_rec_data got=%h exp=0", rec_cacheline); end
    checks++; if (req_full !== 1'b0) begin errors++; $display("FAIL mid_req_full got=%b exp=0", req_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rec_en === 1'b1) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL mid_ghost_resp got=%0d exp=0", n); end
    req_ren = 1'b1; req_raddr = 32'h0000_0200;
    @(negedge clk); req_ren = 1'b0;
    got = 1'b0; rd = '0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rec_en === 1'b1) begin got = 1'b1; rd = rec_cacheline; end
    end
    checks++; if (!got) begin errors++; $display("FAIL mid_reread_timeout got=none exp=response"); end
    checks++; if (rd !== d) begin errors++; $display("FAIL mid_storage got=%h exp=%h", rd, d); end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_latency();
    test_same_cycle();
    test_back_to_back();
    test_write_after_read();
    test_overflow();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data-cache line-fill/write-back interface.
- Accepts write-back requests: full cacheline, posted, no response.
- Accepts line-fill read requests and returns the addressed cacheline after a programmable latency on the receive channel.
- Sits between the data cache and the backing store; it is the behavioural main memory for simulation and small FPGA builds.

Parameters:
- MEM_LATENCY, 5: cycles from read acceptance to response, min 1.
- QUEUE_DEPTH, 4: outstanding read slots, power of two, min 2.
- MEM_LINES, 4096: cachelines of backing storage, power of two.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_ren  in  1  line-fill read request, valid for one cycle.
- req_raddr  in  $bits(pptr_t)  read address, offset bits ignored.
- req_wen  in  1  write-back request, valid for one cycle.
- req_waddr  in  $bits(pptr_t)  write-back address, offset bits ignored.
- req_wcacheline  in  $bits(cacheline_t)  write-back data.
- rec_en  out  1  response valid, high exactly one cycle per read.
- rec_addr  out  $bits(pptr_t)  echoed read address with offset forced to 0.
- rec_cacheline  out  $bits(cacheline_t)  returned line.
- req_full  out  1  read queue full; a read presented now is dropped.
- overflow  out  1  sticky: a read was dropped while full.

Behaviour:
- Reset (rst low, async): rec_en=0, rec_addr=0, rec_cacheline=0, req_full=0, overflow=0; queue emptied; counter=0; FSM=IDLE. Storage contents are not cleared.
- Reset mid-operation discards all outstanding reads. No response is issued for them.
- Line index = paddr line bits (above offset), truncated to log2(MEM_LINES) LSBs.
- Write: on req_wen, storage[line] <= req_wcacheline at that edge. No latency, no queueing, never blocked.
- Read acceptance: on req_ren with queue not full, push {addr with offset zeroed} at the tail.
- Read while full: the request is dropped, overflow <= 1 (clears only on reset), no other state change.
- Simultaneous req_ren and req_wen in the same cycle: both are accepted. The write commits first, so a read of the same line returns the new data.
- Read data is sampled from storage in the response cycle. A write landing between acceptance and response is visible in the returned line.
- FSM (serialized mode), states IDLE, COUNT, RESPOND:
  - IDLE: queue non-empty -> COUNT, counter=1.
  - COUNT: counter increments each cycle; when counter==MEM_LATENCY-1 -> RESPOND.
  - RESPOND: registered rec_en=1, rec_addr=head.addr, rec_cacheline=storage[head line]; pop head. Next state is COUNT with counter=1 if the queue is still non-empty, else IDLE.
  - MEM_LATENCY=1: go straight to RESPOND.
- Timing: a read accepted at edge T with an empty queue gives rec_en high in the cycle after edge T+MEM_LATENCY-1, i.e. MEM_LATENCY edges later.
- Back-to-back reads are spaced MEM_LATENCY cycles apart. Responses are strictly in order.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- req_full reflects occupancy after the edge. A pop in the same cycle does not free a slot for that cycle's request.
- Pointers wrap modulo QUEUE_DEPTH; one extra occupancy bit distinguishes full from empty.
- rec_en returns to 0 the cycle after every response. rec_addr and rec_cacheline hold their last value.

Optional Feature:
- DMEM_RESPONDER_PIPELINED_EN.
- Defined:
  - Each queue slot carries its own age counter, started at acceptance.
  - The head responds when its age >= MEM_LATENCY-1, at most one response per cycle, in order.
  - Response cycle = max(accept+MEM_LATENCY, previous response+1).
  - The COUNT state is removed; the FSM reduces to IDLE/RESPOND.
- Undefined: serialized FSM as above.

Decomposition:
- pptr_t, cacheline_t, the line field layout and the offset width come from common.
- Add dmem_line_idx_t and the DMEM_LATENCY default to common.
- One sub-module: dmem_req_fifo, a parameterized synchronous FIFO with push, pop, full, empty, head.

Test Plan:
- Reset, then write line 0x040 = 0xA5..A5 at cycle 2, read 0x040 at cycle 3 -> rec_en high at cycle 8 (MEM_LATENCY=5), rec_addr=0x0400, data 0xA5..A5.
- Same-cycle wen line 0x010 = 0x11..11 and ren 0x010 -> response data 0x11..11.
- Four reads in consecutive cycles, serialized -> responses at T+5, +10, +15, +20, in order. With DMEM_RESPONDER_PIPELINED_EN -> responses at T+5, +6, +7, +8.
- Five reads with no drain (QUEUE_DEPTH=4) -> req_full high after the fourth; the fifth is dropped; overflow=1 and stays high; exactly four responses.
- Read accepted; write to the same line 2 cycles later -> response carries the new data.
- rst low two cycles after a read -> all outputs 0 immediately; no response ever appears; storage still holds its prior writes.
